axi4_xip_read_slave: RTL and testbench

- AXI4 slave front end of the QSPI XIP path; it answers bursts issued by the CPU-side AXI4 read master.
- Accepts one AR burst at a time and issues one word fetch per beat to the flash fetch engine.
- Returns R beats with the ID echoed and per-beat RRESP.
- The flash is read-only: write bursts are drained and answered with SLVERR.

---
 rtl/axi4_pkg.sv | 18 +
 rtl/axi4_burst_addr_gen.sv | 25 ++
 rtl/axi4_xip_read_slave.sv | 148 ++++++++++++++
 tb/tb_axi4_xip_read_slave.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/axi4_pkg.sv
// axi4_pkg: shared AXI4 response/burst encodings, FSM state types and clog2 helper
package axi4_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_WAIT, R_SEND} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/axi4_burst_addr_gen.sv
// axi4_burst_addr_gen: combinational next-beat address and burst legality for native-size bursts
module axi4_burst_addr_gen
  import axi4_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic [AW-1:0] addr,
  input  logic [7:0]    len,
  input  logic [2:0]    size,
  input  logic [1:0]    burst,
  output logic [AW-1:0] next_addr,
  output logic          burst_legal
);
  localparam int RS = clog2(DATA_WIDTH / 8);
  logic [AW-1:0] incr_addr, wrap_mask, wrap_addr;
  logic          wrap_len_ok;
  assign wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  assign burst_legal = (burst != 2'b11) && !(burst == BURST_WRAP && !wrap_len_ok) && (size == 3'(RS));
  assign incr_addr   = addr + AW'(DATA_WIDTH / 8);
  // wrap window is (len+1) beats; low bits roll over inside it, high bits stay put
  assign wrap_mask   = ((AW'(len) + AW'(1)) << RS) - AW'(1);
  assign wrap_addr   = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
  assign next_addr   = (burst == BURST_FIXED) ? addr : (burst == BURST_WRAP) ? wrap_addr : incr_addr;
endmodule

// File: rtl/axi4_xip_read_slave.sv
// axi4_xip_read_slave: AXI4 read slave for the QSPI XIP path; one word fetch per beat,
// writes are drained and answered with SLVERR since the flash is read-only.
module axi4_xip_read_slave
  import axi4_pkg::*;
#(
  parameter int                        DATA_WIDTH     = 32,
  parameter int                        AXI_ADDR_WIDTH = 32,
  parameter logic [AXI_ADDR_WIDTH-1:0] FLASH_BYTES    = 32'h0100_0000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [3:0]                s_arid,
  input  logic [AXI_ADDR_WIDTH-1:0] s_araddr,
  input  logic [7:0]                s_arlen,
  input  logic [2:0]                s_arsize,
  input  logic [1:0]                s_arburst,
  input  logic                      s_arvalid,
  output logic                      s_arready,
  output logic [3:0]                s_rid,
  output logic [DATA_WIDTH-1:0]     s_rdata,
  output logic [1:0]                s_rresp,
  output logic                      s_rlast,
  output logic                      s_ruser,
  output logic                      s_rvalid,
  input  logic                      s_rready,
  input  logic [3:0]                s_awid,
  input  logic [AXI_ADDR_WIDTH-1:0] s_awaddr,
  input  logic [7:0]                s_awlen,
  input  logic [2:0]                s_awsize,
  input  logic [1:0]                s_awburst,
  input  logic                      s_awvalid,
  output logic                      s_awready,
  input  logic [DATA_WIDTH-1:0]     s_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s_wstrb,
  input  logic                      s_wlast,
  input  logic                      s_wuser,
  input  logic                      s_wvalid,
  output logic                      s_wready,
  output logic [3:0]                s_bid,
  output logic [1:0]                s_bresp,
  output logic                      s_buser,
  output logic                      s_bvalid,
  input  logic                      s_bready,
  output logic                      fetch_valid,
  output logic [AXI_ADDR_WIDTH-1:0] fetch_addr,
  input  logic                      fetch_ready,
  input  logic                      fetch_rvalid,
  input  logic [DATA_WIDTH-1:0]     fetch_rdata,
  input  logic                      fetch_rerr
);
  localparam int AW = AXI_ADDR_WIDTH;
  r_state_t      r_state, r_next;
  w_state_t      w_state, w_next;
  logic [3:0]    r_id;
  logic [AW-1:0] r_addr, nxt_addr;
  logic [7:0]    r_len, r_cnt;
  logic [2:0]    r_size;
  logic [1:0]    r_burst;
  logic          legal, oor, last, unused_ok;
  axi4_burst_addr_gen #(.AW(AW), .DATA_WIDTH(DATA_WIDTH)) u_addr_gen (
    .addr(r_addr), .len(r_len), .size(r_size), .burst(r_burst),
    .next_addr(nxt_addr), .burst_legal(legal)
  );
  assign oor        = r_addr >= FLASH_BYTES;
  assign last       = r_cnt == r_len;
  assign s_rvalid   = r_state == R_SEND;
  assign s_rlast    = s_rvalid && last;
  assign s_rid      = r_id;
  assign s_ruser    = 1'b0;
  assign fetch_addr = r_addr & ~AW'(DATA_WIDTH / 8 - 1);
  assign s_bvalid   = w_state == W_RESP;
  assign s_bresp    = s_bvalid ? RESP_SLVERR : RESP_OKAY;
  assign s_buser    = 1'b0;
  assign unused_ok  = ^{s_awaddr, s_awlen, s_awsize, s_awburst, s_wdata, s_wstrb, s_wuser};
  always_comb begin
    r_next      = r_state;
    fetch_valid = 1'b0;
    case (r_state)
      R_IDLE:  r_next = (s_arvalid && s_arready) ? R_FETCH : R_IDLE;
      R_FETCH: begin
        fetch_valid = legal && !oor;
        r_next      = (!legal || oor) ? R_SEND : fetch_ready ? R_WAIT : R_FETCH;
      end
      R_WAIT:  r_next = fetch_rvalid ? R_SEND : R_WAIT;
      R_SEND:  r_next = !s_rready ? R_SEND : last ? R_IDLE : R_FETCH;
    endcase
  end
  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  w_next = (s_awvalid && s_awready) ? W_DATA : W_IDLE;
      W_DATA:  w_next = (s_wvalid && s_wready && s_wlast) ? W_RESP : W_DATA;
      W_RESP:  w_next = s_bready ? W_IDLE : W_RESP;
      default: w_next = W_IDLE;
    endcase
  end
  // ready outputs are flops so they come out of reset low and rise one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= R_IDLE;
      w_state   <= W_IDLE;
      s_arready <= 1'b0;
      s_awready <= 1'b0;
      s_wready  <= 1'b0;
    end else begin
      r_state   <= r_next;
      w_state   <= w_next;
      s_arready <= r_next == R_IDLE;
      s_awready <= w_next == W_IDLE;
      s_wready  <= w_next == W_DATA;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_cnt   <= '0;
      s_rdata <= '0;
      s_rresp <= RESP_OKAY;
      s_bid   <= '0;
    end else begin
      if (r_state == R_IDLE && s_arvalid && s_arready) begin
        r_id    <= s_arid;
        r_addr  <= s_araddr;
        r_len   <= s_arlen;
        r_size  <= s_arsize;
        r_burst <= s_arburst;
        r_cnt   <= '0;
      end
      if (r_state == R_FETCH && (!legal || oor)) begin
        s_rdata <= '0;
        s_rresp <= legal ? RESP_DECERR : RESP_SLVERR;
      end
      if (r_state == R_WAIT && fetch_rvalid) begin
        s_rdata <= fetch_rdata;
        s_rresp <= fetch_rerr ? RESP_SLVERR : RESP_OKAY;
      end
      if (r_state == R_SEND && s_rready && !last) begin
        r_addr <= nxt_addr;
        r_cnt  <= r_cnt + 8'd1;
      end
      if (w_state == W_IDLE && s_awvalid && s_awready) s_bid <= s_awid;
    end
  end
endmodule

// File: tb/tb_axi4_xip_read_slave.sv
// tb_axi4_xip_read_slave: table-driven read bursts against a 2-cycle fetch engine model,
// plus concurrent write rejection and mid-burst reset sequences.
module tb_axi4_xip_read_slave;
  logic        clk, rst_n;
  logic [3:0]  s_arid, s_rid, s_awid, s_bid;
  logic [31:0] s_araddr, s_rdata, s_awaddr, s_wdata, fetch_addr, fetch_rdata;
  logic [7:0]  s_arlen, s_awlen;
  logic [2:0]  s_arsize, s_awsize;
  logic [1:0]  s_arburst, s_rresp, s_awburst, s_bresp;
  logic        s_arvalid, s_arready, s_rlast, s_ruser, s_rvalid, s_rready;
  logic        s_awvalid, s_awready, s_wlast, s_wuser, s_wvalid, s_wready;
  logic [3:0]  s_wstrb;
  logic        s_buser, s_bvalid, s_bready;
  logic        fetch_valid, fetch_ready, fetch_rvalid, fetch_rerr;
  axi4_xip_read_slave dut (
    .clk(clk), .rst_n(rst_n),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_ruser(s_ruser), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wuser(s_wuser),
    .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_buser(s_buser), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .fetch_valid(fetch_valid), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata), .fetch_rerr(fetch_rerr)
  );
  typedef struct packed {
    logic [3:0]        id;
    logic [31:0]       addr;
    logic [7:0]        len;
    logic [2:0]        sz;
    logic [1:0]        bu;
    int                stall;
    int                err;
    int                nf;
    logic [0:3][31:0]  fa;
    logic [0:3][31:0]  d;
    logic [0:3][1:0]   r;
  } vec_t;
  vec_t        vt [12];
  int          total = 0, bad = 0;
  logic [31:0] fq [$];
  int          fcnt = 0, err_idx = -1, cd = 0;
  logic [31:0] pend_d = 0;
  logic        pend_e = 0, stale = 0;
  initial clk = 0;
  always #5 clk = ~clk;
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endfunction
  // fetch engine: ready toggles every cycle, response pulses 2 cycles after acceptance
  initial begin
    fetch_ready = 0; fetch_rvalid = 0; fetch_rdata = 0; fetch_rerr = 0;
    forever begin
      @(negedge clk);
      fetch_rvalid = 0;
      fetch_rerr = 0;
      if (cd == 1) begin
        fetch_rvalid = 1;
        fetch_rdata = stale ? 32'hDEAD_BEEF : pend_d;
        fetch_rerr = stale ? 1'b0 : pend_e;
        stale = 0;
      end
      if (cd > 0) cd--;
      fetch_ready = !fetch_ready;
      if (fetch_valid && fetch_ready && rst_n) begin
        fq.push_back(fetch_addr);
        pend_d = 32'hA0 + fcnt;
        pend_e = (fcnt == err_idx);
        fcnt++;
        cd = 2;
      end
    end
  end
  task automatic send_ar(input logic [3:0] id, input logic [31:0] a, input logic [7:0] l,
                         input logic [2:0] sz, input logic [1:0] bu);
    int n;
    @(negedge clk);
    s_arid = id; s_araddr = a; s_arlen = l; s_arsize = sz; s_arburst = bu; s_arvalid = 1;
    n = 0;
    while (!s_arready && n < 20) begin @(negedge clk); n++; end
    chk("ar_handshake", 32'(n < 20), 1);
    @(negedge clk);
    s_arvalid = 0;
  endtask
  task automatic run_vec(input int k, input vec_t v);
    int n;
    fq.delete(); fcnt = 0; err_idx = v.err;
    send_ar(v.id, v.addr, v.len, v.sz, v.bu);
    for (int b = 0; b <= int'(v.len); b++) begin
      s_rready = (b != v.stall);
      n = 0;
      while (!s_rvalid && n < 60) begin @(negedge clk); n++; end
      chk($sformatf("v%0d b%0d rvalid", k, b), 32'(s_rvalid), 1);
      chk($sformatf("v%0d b%0d rdata", k, b), s_rdata, v.d[b]);
      chk($sformatf("v%0d b%0d rresp", k, b), 32'(s_rresp), 32'(v.r[b]));
      chk($sformatf("v%0d b%0d rlast", k, b), 32'(s_rlast), 32'(b == int'(v.len)));
      chk($sformatf("v%0d b%0d rid", k, b), 32'(s_rid), 32'(v.id));
      if (b == v.stall) begin
        repeat (5) begin
          @(negedge clk);
          chk($sformatf("v%0d hold rvalid", k), 32'(s_rvalid), 1);
          chk($sformatf("v%0d hold rdata", k), s_rdata, v.d[b]);
          chk($sformatf("v%0d hold rresp", k), 32'(s_rresp), 32'(v.r[b]));
          chk($sformatf("v%0d hold rlast", k), 32'(s_rlast), 32'(b == int'(v.len)));
        end
        s_rready = 1;
      end
      @(negedge clk);
    end
    chk($sformatf("v%0d no_extra_beat", k), 32'(s_rvalid), 0);
    repeat (3) @(negedge clk);
    chk($sformatf("v%0d nfetch", k), fq.size(), v.nf);
    for (int i = 0; i < v.nf && i < fq.size(); i++)
      chk($sformatf("v%0d fetch_addr%0d", k, i), fq[i], v.fa[i]);
  endtask
  task automatic do_write();
    int n, acc;
    @(negedge clk);
    s_awid = 4'd9; s_awaddr = 32'h40; s_awlen = 8'd2; s_awsize = 3'd2; s_awburst = 2'd1; s_awvalid = 1;
    n = 0;
    while (!s_awready && n < 20) begin @(negedge clk); n++; end
    chk("aw_handshake", 32'(n < 20), 1);
    @(negedge clk);
    s_awvalid = 0;
    acc = 0;
    for (int w = 0; w < 3; w++) begin
      s_wdata = 32'h5555_0000 + w; s_wstrb = 4'hF; s_wlast = (w == 2); s_wvalid = 1;
      n = 0;
      while (!s_wready && n < 20) begin @(negedge clk); n++; end
      if (s_wready) acc++;
      chk($sformatf("no_early_b w%0d", w), 32'(s_bvalid), 0);
      @(negedge clk);
    end
    s_wvalid = 0; s_wlast = 0;
    chk("w_accepted", acc, 3);
    n = 0;
    while (!s_bvalid && n < 20) begin @(negedge clk); n++; end
    chk("bvalid", 32'(s_bvalid), 1);
    chk("bid", 32'(s_bid), 9);
    chk("bresp", 32'(s_bresp), 2);
    chk("wready_off_in_resp", 32'(s_wready), 0);
    s_bready = 1;
    @(negedge clk);
    s_bready = 0;
    chk("b_done", 32'(s_bvalid), 0);
  endtask
  initial begin
    int n;
    //         id    addr           len   sz    burst stall err nf fetch addresses                                  data                                     resp
    vt[0]  = '{4'd5, 32'h100,      8'd3, 3'd2, 2'd1, -1, -1, 4, '{32'h100, 32'h104, 32'h108, 32'h10C}, '{32'hA0, 32'hA1, 32'hA2, 32'hA3}, '{2'd0, 2'd0, 2'd0, 2'd0}};
    vt[1]  = '{4'd1, 32'h38,       8'd3, 3'd2, 2'd2, -1, -1, 4, '{32'h38, 32'h3C, 32'h30, 32'h34},     '{32'hA0, 32'hA1, 32'hA2, 32'hA3}, '{2'd0, 2'd0, 2'd0, 2'd0}};
    vt[2]  = '{4'd2, 32'h38,       8'd2, 3'd2, 2'd2, -1, -1, 0, '{32'h0, 32'h0, 32'h0, 32'h0},         '{32'h0, 32'h0, 32'h0, 32'h0},     '{2'd2, 2'd2, 2'd2, 2'd0}};
    vt[3]  = '{4'd3, 32'hFF_FFF8,  8'd3, 3'd2, 2'd1, -1, -1, 2, '{32'hFF_FFF8, 32'hFF_FFFC, 32'h0, 32'h0}, '{32'hA0, 32'hA1, 32'h0, 32'h0},  '{2'd0, 2'd0, 2'd3, 2'd3}};
    vt[4]  = '{4'd8, 32'h300,      8'd3, 3'd2, 2'd1,  1,  2, 4, '{32'h300, 32'h304, 32'h308, 32'h30C}, '{32'hA0, 32'hA1, 32'hA2, 32'hA3}, '{2'd0, 2'd0, 2'd2, 2'd0}};
    vt[5]  = '{4'd4, 32'h200,      8'd1, 3'd2, 2'd0, -1, -1, 2, '{32'h200, 32'h200, 32'h0, 32'h0},     '{32'hA0, 32'hA1, 32'h0, 32'h0},   '{2'd0, 2'd0, 2'd0, 2'd0}};
    vt[6]  = '{4'd10, 32'h3C,      8'd1, 3'd2, 2'd2, -1, -1, 2, '{32'h3C, 32'h38, 32'h0, 32'h0},       '{32'hA0, 32'hA1, 32'h0, 32'h0},   '{2'd0, 2'd0, 2'd0, 2'd0}};
    vt[7]  = '{4'd11, 32'h103,     8'd1, 3'd2, 2'd1, -1, -1, 2, '{32'h100, 32'h104, 32'h0, 32'h0},     '{32'hA0, 32'hA1, 32'h0, 32'h0},   '{2'd0, 2'd0, 2'd0, 2'd0}};
    vt[8]  = '{4'd6, 32'h10,       8'd0, 3'd1, 2'd1, -1, -1, 0, '{32'h0, 32'h0, 32'h0, 32'h0},         '{32'h0, 32'h0, 32'h0, 32'h0},     '{2'd2, 2'd0, 2'd0, 2'd0}};
    vt[9]  = '{4'd7, 32'h10,       8'd0, 3'd2, 2'd3, -1, -1, 0, '{32'h0, 32'h0, 32'h0, 32'h0},         '{32'h0, 32'h0, 32'h0, 32'h0},     '{2'd2, 2'd0, 2'd0, 2'd0}};
    vt[10] = '{4'd12, 32'h100_0000, 8'd0, 3'd2, 2'd1, -1, -1, 0, '{32'h0, 32'h0, 32'h0, 32'h0},        '{32'h0, 32'h0, 32'h0, 32'h0},     '{2'd3, 2'd0, 2'd0, 2'd0}};
    vt[11] = '{4'd6, 32'h0,        8'd0, 3'd2, 2'd1, -1, -1, 1, '{32'h0, 32'h0, 32'h0, 32'h0},         '{32'hA0, 32'h0, 32'h0, 32'h0},    '{2'd0, 2'd0, 2'd0, 2'd0}};
    rst_n = 0;
    s_arid = 0; s_araddr = 0; s_arlen = 0; s_arsize = 0; s_arburst = 0; s_arvalid = 0; s_rready = 1;
    s_awid = 0; s_awaddr = 0; s_awlen = 0; s_awsize = 0; s_awburst = 0; s_awvalid = 0;
    s_wdata = 0; s_wstrb = 0; s_wlast = 0; s_wuser = 0; s_wvalid = 0; s_bready = 0;
    #12;
    chk("rst arready", 32'(s_arready), 0);
    chk("rst awready", 32'(s_awready), 0);
    chk("rst rvalid", 32'(s_rvalid), 0);
    chk("rst bvalid", 32'(s_bvalid), 0);
    chk("rst fetch_valid", 32'(fetch_valid), 0);
    #10 rst_n = 1;
    repeat (2) @(negedge clk);
    chk("idle arready", 32'(s_arready), 1);
    chk("idle awready", 32'(s_awready), 1);
    chk("idle wready", 32'(s_wready), 0);
    for (int k = 0; k <= 10; k++) run_vec(k, vt[k]);
    fork
      run_vec(50, vt[0]);
      do_write();
    join
    // reset while the read FSM waits for a fetch response
    fq.delete(); fcnt = 0; err_idx = -1;
    send_ar(4'd3, 32'h400, 8'd0, 3'd2, 2'd1);
    n = 0;
    while (fq.size() == 0 && n < 20) begin @(posedge clk); #1; n++; end
    chk("pre_rst fetch_issued", fq.size(), 1);
    chk("pre_rst rid", 32'(s_rid), 3);
    chk("pre_rst fetch_addr", fetch_addr, 32'h400);
    #1 rst_n = 0; stale = 1;
    #1;
    chk("mid_rst rid", 32'(s_rid), 0);
    chk("mid_rst fetch_addr", fetch_addr, 0);
    chk("mid_rst rvalid", 32'(s_rvalid), 0);
    chk("mid_rst rdata", s_rdata, 0);
    chk("mid_rst rresp", 32'(s_rresp), 0);
    chk("mid_rst arready", 32'(s_arready), 0);
    chk("mid_rst fetch_valid", 32'(fetch_valid), 0);
    #1 rst_n = 1;
    run_vec(11, vt[11]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
